// File: rtl/turn_tracker.sv
// turn_tracker: turn controller for N-player grid games.
// Takes move requests over a valid/ready handshake and rejects illegal cells.
// Tracks cell occupancy and owner, rotates the current player round-robin,
// counts accepted moves and flags a full board.
//
// Optional feature: define TURN_TIMEOUT_EN to add an idle-turn forfeit
// counter and the timeout_pulse output port.
//
// Ports:
//   clk, reset     clock (rising edge), synchronous active-high reset
//   start          begin/restart a game (clears the board)
//   move_valid     move request present
//   move_cell      target cell index
//   move_ready     moves accepted (state PLAY), decoded from state
//   move_ack       1-cycle pulse: previous move accepted
//   move_reject    1-cycle pulse: previous move illegal
//   cur_player     id of the player to move
//   board_occ      bit i = cell i occupied
//   board_owner    owner id of cell i at [i*PW +: PW]; 0 when empty
//   move_count     accepted moves this game
//   board_full     high while the game is DONE
//   timeout_pulse  1-cycle forfeit pulse (TURN_TIMEOUT_EN only)
module turn_tracker #(
  parameter int unsigned CELLS          = 9,
  parameter int unsigned NUM_PLAYERS    = 2,
  parameter int unsigned FIRST_PLAYER   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  localparam int unsigned CW = $clog2(CELLS),
  localparam int unsigned PW = $clog2(NUM_PLAYERS),
  localparam int unsigned NW = $clog2(CELLS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                move_valid,
  input  logic [CW-1:0]       move_cell,
  output logic                move_ready,
  output logic                move_ack,
  output logic                move_reject,
  output logic [PW-1:0]       cur_player,
  output logic [CELLS-1:0]    board_occ,
  output logic [CELLS*PW-1:0] board_owner,
  output logic [NW-1:0]       move_count,
  output logic                board_full
`ifdef TURN_TIMEOUT_EN
  , output logic              timeout_pulse
`endif
);

  // Elaboration-time sanity check of the configuration.
  if (CELLS < 2 || NUM_PLAYERS < 2 || FIRST_PLAYER >= NUM_PLAYERS || TIMEOUT_CYCLES == 0)
  begin : g_bad_cfg
    $error("turn_tracker: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CELLS-1:0]      occ_q, occ_d;
  logic [CELLS*PW-1:0]   owner_q, owner_d;
  logic [NW-1:0]         count_q, count_d;
  logic [PW-1:0]         player_q, player_d;
  logic                  ack_q, ack_d;
  logic                  rej_q, rej_d;
  logic                  full_q, full_d;

  logic                  handshake;
  logic                  cell_match;
  logic                  cell_taken;
  logic                  accept;
  logic [PW-1:0]         player_next;

`ifdef TURN_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]         idle_q, idle_d;
  logic                  tmo_q, tmo_d;
`endif

  assign move_ready  = (state_q == S_PLAY);
  assign move_ack    = ack_q;
  assign move_reject = rej_q;
  assign cur_player  = player_q;
  assign board_occ   = occ_q;
  assign board_owner = owner_q;
  assign move_count  = count_q;
  assign board_full  = full_q;
`ifdef TURN_TIMEOUT_EN
  assign timeout_pulse = tmo_q;
`endif

  // Cell lookup: an index that matches no cell is out of range.
  always_comb begin
    cell_match = 1'b0;
    cell_taken = 1'b0;
    for (int i = 0; i < int'(CELLS); i++) begin
      if (move_cell == CW'(i)) begin
        cell_match = 1'b1;
        cell_taken = occ_q[i];
      end
    end
  end

  assign handshake   = move_valid && move_ready;
  assign accept      = handshake && !start && cell_match && !cell_taken;
  assign player_next = (player_q == PW'(NUM_PLAYERS - 1)) ? '0 : player_q + PW'(1);

  // Next-state and datapath update; start outranks any handshake.
  always_comb begin
    state_d  = state_q;
    occ_d    = occ_q;
    owner_d  = owner_q;
    count_d  = count_q;
    player_d = player_q;
    ack_d    = 1'b0;
    rej_d    = 1'b0;
`ifdef TURN_TIMEOUT_EN
    idle_d   = '0;
    tmo_d    = 1'b0;
`endif

    if (start) begin
      state_d  = S_PLAY;
      occ_d    = '0;
      owner_d  = '0;
      count_d  = '0;
      player_d = PW'(FIRST_PLAYER);
    end else if (accept) begin
      ack_d    = 1'b1;
      count_d  = count_q + NW'(1);
      player_d = player_next;
      for (int i = 0; i < int'(CELLS); i++) begin
        if (move_cell == CW'(i)) begin
          occ_d[i]             = 1'b1;
          owner_d[i*PW +: PW]  = player_q;
        end
      end
      if (count_q == NW'(CELLS - 1)) begin
        state_d = S_DONE;
      end
    end else if (handshake) begin
      rej_d = 1'b1;
    end

`ifdef TURN_TIMEOUT_EN
    // Idle counter only advances in PLAY cycles without start or accepted move.
    if (state_q == S_PLAY && !start && !accept) begin
      if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
        tmo_d    = 1'b1;
        player_d = player_next;
      end else begin
        idle_d = idle_q + TW'(1);
      end
    end
`endif

    full_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      occ_q    <= '0;
      owner_q  <= '0;
      count_q  <= '0;
      player_q <= PW'(FIRST_PLAYER);
      ack_q    <= 1'b0;
      rej_q    <= 1'b0;
      full_q   <= 1'b0;
`ifdef TURN_TIMEOUT_EN
      idle_q   <= '0;
      tmo_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      occ_q    <= occ_d;
      owner_q  <= owner_d;
      count_q  <= count_d;
      player_q <= player_d;
      ack_q    <= ack_d;
      rej_q    <= rej_d;
      full_q   <= full_d;
`ifdef TURN_TIMEOUT_EN
      idle_q   <= idle_d;
      tmo_q    <= tmo_d;
`endif
    end
  end

endmodule
